// File: rtl/seq_mac_pkg.sv
// Shared definitions for the nibble-serial multiply-accumulate block:
// FSM state encoding, nibble/byte widths and a counter-width helper.
package seq_mac_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Width of an index counting 0..n-1; a single-entry range still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mac_nibble_if.sv
// Pin-level bus of the nibble MAC: 8 input pins (clock, reset, strobe, mode,
// data nibble) and the 8-bit result window.
interface seq_mac_nibble_if;

  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);

endinterface

// File: rtl/seq_mac_datapath.sv
// Shift-and-add datapath: operand nibble capture, multiplicand/multiplier
// shift registers, accumulator and multiplier bit counter.
module seq_mac_datapath
  import seq_mac_pkg::*;
#(
  parameter int W      = 8,
  parameter int ACC_W  = 24,
  localparam int NIBS   = 2 * W / NIB_W,
  localparam int NCNT_W = idx_width(NIBS),
  localparam int BIT_W  = idx_width(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [NCNT_W-1:0] cap_idx,
  input  logic [NIB_W-1:0]  cap_nib,
  input  logic              mul_start,
  input  logic              acc_mode,
  input  logic              step,
  output logic [ACC_W-1:0]  acc,
  output logic              mul_done
);

  logic [2*W-1:0]   ops_q;
  logic [2*W-1:0]   ops_d;
  logic [ACC_W-1:0] mcand_q;
  logic [W-1:0]     mplier_q;
  logic [ACC_W-1:0] acc_q;
  logic [BIT_W-1:0] bit_cnt_q;

  // Operands live as {B, A}; nibble k lands at bits 4k+3:4k.
  always_comb begin
    ops_d = ops_q;
    if (cap_en) ops_d[NIB_W*int'(cap_idx) +: NIB_W] = cap_nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      ops_q <= ops_d;
      if (mul_start) begin
        // Load from ops_d so the final nibble captured this edge is included.
        mcand_q   <= ACC_W'(ops_d[W-1:0]);
        mplier_q  <= ops_d[2*W-1:W];
        bit_cnt_q <= '0;
        if (!acc_mode) acc_q <= '0;
      end else if (step) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q   <= mcand_q << 1;
        mplier_q  <= mplier_q >> 1;
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
    end
  end

  assign acc      = acc_q;
  assign mul_done = (bit_cnt_q == BIT_W'(W - 1));

endmodule

// File: rtl/seq_mac_nibble.sv
// Nibble-serial multiply / multiply-accumulate: loads A then B a nibble at a
// time, multiplies in W shift-add cycles, then streams the accumulator bytes.
module seq_mac_nibble
  import seq_mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 24
) (
  seq_mac_nibble_if.slave bus
);

  localparam int NIBS   = 2 * W / NIB_W;
  localparam int NCNT_W = idx_width(NIBS);
  localparam int BYTES  = ACC_W / BYTE_W;
  localparam int IDX_W  = idx_width(BYTES);
  localparam logic [NCNT_W-1:0] LAST_NIB  = NCNT_W'(NIBS - 1);
  localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(BYTES - 1);

  logic             clk;
  logic             rst;
  logic             ld;
  logic             mode;
  logic [NIB_W-1:0] nib;

  assign clk  = bus.io_in[0];
  assign rst  = bus.io_in[1];
  assign ld   = bus.io_in[2];
  assign mode = bus.io_in[3];
  assign nib  = bus.io_in[7:4];

  state_t              state_q;
  logic [NCNT_W-1:0]   nib_cnt_q;
  logic                mode_q;
  logic [IDX_W-1:0]    idx_q;
  logic [BYTE_W-1:0]   out_q;

  logic                cap_en;
  logic [NCNT_W-1:0]   cap_idx;
  logic                mul_start;
  logic                step;
  logic [ACC_W-1:0]    acc;
  logic                mul_done;

  assign cap_en    = ld && (state_q == IDLE || state_q == LOAD);
  assign cap_idx   = (state_q == LOAD) ? nib_cnt_q : '0;
  assign mul_start = ld && (state_q == LOAD) && (nib_cnt_q == LAST_NIB);
  assign step      = (state_q == MUL);

  seq_mac_datapath #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_en),
    .cap_idx   (cap_idx),
    .cap_nib   (nib),
    .mul_start (mul_start),
    .acc_mode  (mode_q),
    .step      (step),
    .acc       (acc),
    .mul_done  (mul_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nib_cnt_q <= '0;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      out_q     <= '0;
    end else begin
      // Output register: the byte window trails the OUT state by one edge.
      out_q <= (state_q == OUT) ? acc[BYTE_W*int'(idx_q) +: BYTE_W] : '0;
      case (state_q)
        IDLE: if (ld) begin
          nib_cnt_q <= NCNT_W'(1);
          mode_q    <= mode;
          state_q   <= LOAD;
        end
        LOAD: if (ld) begin
          if (nib_cnt_q == LAST_NIB) begin
            nib_cnt_q <= '0;
            state_q   <= MUL;
          end else begin
            nib_cnt_q <= nib_cnt_q + NCNT_W'(1);
          end
        end
        MUL: if (mul_done) begin
          idx_q   <= '0;
          state_q <= OUT;
        end
        OUT: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_BYTE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.io_out = out_q;

endmodule

// File: tb/tb_seq_mac_nibble.sv
// Randomized self-checking bench for seq_mac_nibble against an arithmetic
// reference (acc = acc*mode + A*B mod 2^ACC_W, bytes W+1 edges after load).
module tb_seq_mac_nibble;

  localparam int W     = 8;
  localparam int ACC_W = 24;
  localparam int NB    = ACC_W / 8;

  logic       clk = 1'b0;
  logic       rst, ld, mode;
  logic [3:0] nib;
  logic       rst2, ld2, mode2;
  logic [3:0] nib2;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint acc_m  = 0;
  longint acc2_m = 0;

  seq_mac_nibble_if bus ();
  seq_mac_nibble_if bus2 ();

  assign bus.io_in  = {nib, mode, ld, rst, clk};
  assign bus2.io_in = {nib2, mode2, ld2, rst2, clk};

  seq_mac_nibble #(.W(8), .ACC_W(24)) dut   (.bus(bus));
  seq_mac_nibble #(.W(4), .ACC_W(8))  dut_s (.bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: io_out=%0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected io_out e edges after the last-nibble edge.
  function automatic logic [63:0] exp_out(input int e, input longint acc, input int w, input int nb);
    if (e >= w + 1 && e <= w + nb) return 64'((acc >> (8 * (e - w - 1))) & 255);
    return 64'd0;
  endfunction

  function automatic longint mac(input longint acc, input bit m, input int a, input int b, input int accw);
    longint r;
    r = (m ? acc : 64'd0) + longint'(a) * longint'(b);
    return r & ((longint'(1) << accw) - 1);
  endfunction

  // Called at a negedge; returns at the negedge where the next op may start.
  task automatic run_op(input bit m, input int a, input int b, input bit gaps, input bit noise);
    logic [15:0] ops;
    ops = {b[7:0], a[7:0]};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("load", bus.io_out, 0);
        if (gaps) repeat ($urandom_range(0, 2)) begin
          ld = 1'b0; nib = 4'($urandom); mode = 1'($urandom);
          @(negedge clk);
          chk("gap", bus.io_out, 0);
        end
      end
      ld   = 1'b1;
      nib  = ops[4*i +: 4];
      mode = (i == 0) ? m : 1'($urandom);
    end
    acc_m = mac(acc_m, m, a, b, ACC_W);
    for (int k = 1; k <= W + NB + 1; k++) begin
      @(negedge clk);
      chk("mac", bus.io_out, exp_out(k - 1, acc_m, W, NB));
      if (noise && k <= W + NB) begin
        ld = 1'($urandom); nib = 4'($urandom); mode = 1'($urandom);
      end else begin
        ld = 1'b0;
      end
    end
  endtask

  // stage 0: reset after two nibbles; stage k>0: reset sampled k edges after load.
  task automatic abort_op(input bit m, input int a, input int b, input int stage);
    logic [15:0] ops;
    longint acc_new;
    ops = {b[7:0], a[7:0]};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("ab_load", bus.io_out, 0);
      end
      if (stage == 0 && i == 2) begin
        rst = 1'b1; ld = 1'b1;
        break;
      end
      ld   = 1'b1;
      nib  = ops[4*i +: 4];
      mode = (i == 0) ? m : 1'($urandom);
    end
    if (stage > 0) begin
      acc_new = mac(acc_m, m, a, b, ACC_W);
      for (int k = 1; k <= stage; k++) begin
        @(negedge clk);
        chk("ab_pre", bus.io_out, exp_out(k - 1, acc_new, W, NB));
        ld = 1'b0;
      end
      rst = 1'b1; ld = 1'b1;
    end
    acc_m = 0;
    @(negedge clk);
    rst = 1'b0; ld = 1'b0;
    repeat (W + NB + 2) begin
      chk("ab_post", bus.io_out, 0);
      @(negedge clk);
    end
  endtask

  task automatic run_small(input bit m, input int a, input int b);
    ld2 = 1'b1; nib2 = 4'(a); mode2 = m;
    @(negedge clk);
    chk("s_load", bus2.io_out, 0);
    nib2 = 4'(b); mode2 = 1'($urandom);
    acc2_m = mac(acc2_m, m, a, b, 8);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("s_mac", bus2.io_out, exp_out(k - 1, acc2_m, 4, 1));
      ld2 = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: io_out stream still running, expected end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ld = 1'b1; mode = 1'b1; nib = 4'h5;
    rst2 = 1'b1; ld2 = 1'b0; mode2 = 1'b0; nib2 = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst", bus.io_out, 0);
    chk("rst_s", bus2.io_out, 0);
    rst = 1'b0; ld = 1'b0;

    run_op(0, 3, 7, 0, 0);
    run_op(0, 255, 255, 0, 0);
    run_op(0, 200, 200, 0, 0);
    run_op(1, 200, 200, 0, 0);
    abort_op(0, 100, 100, 4);
    run_op(1, 3, 7, 0, 0);
    run_op(0, 3, 7, 1, 1);
    abort_op(1, 55, 66, 0);
    run_op(1, 9, 9, 1, 0);
    abort_op(1, 55, 66, W + 3);
    run_op(1, 12, 34, 0, 1);

    for (int n = 0; n < 40; n++)
      run_op(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
             1'($urandom), 1'($urandom));
    // Long accumulate run to carry the accumulator past 2^ACC_W.
    run_op(0, $urandom_range(200, 255), $urandom_range(200, 255), 0, 0);
    for (int n = 0; n < 360; n++)
      run_op(1, $urandom_range(200, 255), $urandom_range(200, 255),
             1'($urandom), 1'($urandom));
    repeat (3) begin
      @(negedge clk);
      chk("idle", bus.io_out, 0);
    end

    rst2 = 1'b0;
    run_small(0, 15, 15);
    run_small(1, 15, 15);
    for (int n = 0; n < 12; n++)
      run_small(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
    repeat (2) begin
      @(negedge clk);
      chk("s_idle", bus2.io_out, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
